// File: rtl/led_matrix_scan_ctrl.sv
// ============================================================================
// led_matrix_scan_ctrl
//
// Drives an external LED matrix through two shift-register chains: a one-hot
// row chain (rclk/rsdi) and a column chain (cclk/csdi). Both chains share one
// latch strobe (le) and one active-low output enable (oeb).
//
// Each scan slot has five steps:
//   1. Fetch one row of pixels from the framebuffer over a req/ack port.
//   2. Shift the row out on the column chain, MSB first. Each bit takes two
//      cycles: a setup cycle and a clock cycle.
//   3. Shift one bit into the row chain. The bit is 1 only for row 0, so a
//      single 1 walks down the chain.
//   4. Pulse le for one cycle.
//   5. Keep the row lit for DWELL cycles.
//
// Row period = fetch cycles (including ack wait) + 2*COLS + 2 + 1 + DWELL.
//
// Every output comes straight from a flop. The output comb block computes the
// value each output will have in the next state, and the register block
// stores it.
//
// Optional feature, macro LED_SCAN_BLANK_EN:
//   defined   : oeb is 0 only in DWELL. The matrix is blanked while the
//               chains shift.
//   undefined : oeb stays 0 from the first DWELL until the return to IDLE.
//
// Parameters:
//   ROWS  : number of matrix rows (>= 2)
//   COLS  : number of matrix columns (>= 1); this is also the fb_data width
//   DWELL : cycles a latched row stays lit (>= 1)
//
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   enable      : scanning allowed when high
//   fb_req      : framebuffer read request
//   fb_addr     : row index being requested
//   fb_ack      : framebuffer data valid
//   fb_data     : row pixels; bit i = column i, 1 = lit
//   rclk, rsdi  : row chain shift clock and serial data
//   cclk, csdi  : column chain shift clock and serial data
//   le          : latch strobe for both chains
//   oeb         : output enable, active low
//   frame_start : one-cycle pulse in the first FETCH cycle of row 0
// ============================================================================
module led_matrix_scan_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    fb_req,
    output logic [$clog2(ROWS)-1:0] fb_addr,
    input  logic                    fb_ack,
    input  logic [COLS-1:0]         fb_data,
    output logic                    rclk,
    output logic                    rsdi,
    output logic                    cclk,
    output logic                    csdi,
    output logic                    le,
    output logic                    oeb,
    output logic                    frame_start
);

    localparam int RW      = $clog2(ROWS);
    localparam int CNT_TOP = (2 * COLS > DWELL) ? 2 * COLS : DWELL;
    localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT_COL,
        ST_SHIFT_ROW,
        ST_LATCH,
        ST_DWELL
    } state_t;

    state_t          state_q, state_n;
    logic [RW-1:0]   row_q,   row_n;
    logic [CW-1:0]   cnt_q,   cnt_n;
    logic [COLS-1:0] sh_q,    sh_n;

    logic fb_req_n, rclk_n, rsdi_n, cclk_n, csdi_n, le_n, oeb_n, frame_start_n;

    assign fb_addr = row_q;

    // ------------------------------------------------------------------------
    // State register and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            fb_req      <= 1'b0;
            rclk        <= 1'b0;
            rsdi        <= 1'b0;
            cclk        <= 1'b0;
            csdi        <= 1'b0;
            le          <= 1'b0;
            oeb         <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_n;
            row_q       <= row_n;
            cnt_q       <= cnt_n;
            sh_q        <= sh_n;
            fb_req      <= fb_req_n;
            rclk        <= rclk_n;
            rsdi        <= rsdi_n;
            cclk        <= cclk_n;
            csdi        <= csdi_n;
            le          <= le_n;
            oeb         <= oeb_n;
            frame_start <= frame_start_n;
        end
    end

`ifndef LED_SCAN_BLANK_EN
    // Set once the first row has reached DWELL. While it is set, the matrix
    // keeps showing the previous row as the next one shifts in.
    logic lit_q, lit_n;

    always_comb begin
        lit_n = lit_q;
        if (state_n == ST_IDLE) begin
            lit_n = 1'b0;
        end else if (state_n == ST_DWELL) begin
            lit_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lit_q <= 1'b0;
        end else begin
            lit_q <= lit_n;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        cnt_n   = cnt_q;
        sh_n    = sh_q;
        case (state_q)
            ST_IDLE: begin
                row_n = '0;
                cnt_n = '0;
                if (enable) begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fb_ack) begin
                    sh_n    = fb_data;
                    cnt_n   = '0;
                    state_n = ST_SHIFT_COL;
                end
            end
            ST_SHIFT_COL: begin
                // Move the next bit into the MSB once the current bit's
                // clock cycle (odd count) is done.
                if (cnt_q[0]) begin
                    sh_n = sh_q << 1;
                end
                if (cnt_q == CW'(2 * COLS - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_SHIFT_ROW;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_SHIFT_ROW: begin
                if (cnt_q == CW'(1)) begin
                    cnt_n   = '0;
                    state_n = ST_LATCH;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                cnt_n   = '0;
                state_n = ST_DWELL;
            end
            ST_DWELL: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_n = '0;
                    if (enable) begin
                        state_n = ST_FETCH;
                        row_n   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        row_n   = '0;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                row_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: computed from the next state so the registered outputs
    // line up with the state they describe.
    // ------------------------------------------------------------------------
    always_comb begin
        fb_req_n      = 1'b0;
        rclk_n        = 1'b0;
        rsdi_n        = 1'b0;
        cclk_n        = 1'b0;
        csdi_n        = 1'b0;
        le_n          = 1'b0;
        frame_start_n = (state_n == ST_FETCH) && (state_q != ST_FETCH) && (row_n == '0);
        case (state_n)
            ST_FETCH:     fb_req_n = 1'b1;
            ST_SHIFT_COL: begin
                csdi_n = sh_n[COLS-1];
                cclk_n = cnt_n[0];
            end
            ST_SHIFT_ROW: begin
                rsdi_n = (row_n == '0);
                rclk_n = cnt_n[0];
            end
            ST_LATCH:     le_n = 1'b1;
            default:      ;
        endcase
`ifdef LED_SCAN_BLANK_EN
        oeb_n = (state_n != ST_DWELL);
`else
        oeb_n = !((state_n == ST_DWELL) || (lit_q && (state_n != ST_IDLE)));
`endif
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// ============================================================================
// tb_led_matrix_scan_ctrl
//
// Self-checking bench for led_matrix_scan_ctrl with the default parameters.
// The expected output vector for every cycle of a row comes from the row
// timing rules: fetch with ack wait, column shift, row shift, latch, dwell.
// ============================================================================
module tb_led_matrix_scan_ctrl;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DWELL = 16;
`ifdef LED_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            fb_req;
    logic [2:0]      fb_addr;
    logic            fb_ack;
    logic [COLS-1:0] fb_data;
    logic            rclk, rsdi, cclk, csdi, le, oeb, frame_start;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit lit_exp = 1'b0;
    int fs_t[$];
    int le_t[$];
    bit cb[$];

    led_matrix_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fb_req(fb_req), .fb_addr(fb_addr), .fb_ack(fb_ack), .fb_data(fb_data),
        .rclk(rclk), .rsdi(rsdi), .cclk(cclk), .csdi(csdi),
        .le(le), .oeb(oeb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output vector layout: {fb_req, fb_addr[2:0], frame_start, rclk, rsdi, cclk, csdi, le, oeb}
    function automatic logic [10:0] obs();
        return {fb_req, fb_addr, frame_start, rclk, rsdi, cclk, csdi, le, oeb};
    endfunction

    localparam logic [10:0] IDLE_VEC = 11'b0_000_000000_1;

    // Called at the observation point of the first FETCH cycle of row r.
    // On return the bench is at the observation point of the cycle after the
    // row. That cycle is the next FETCH, IDLE, or the cycle after a reset.
    task automatic do_row(input int r, input logic [COLS-1:0] d, input int w,
                          input bit en_end, input int dis_at, input int abort_at);
        int total;
        int k;
        bit e_req, e_fs, e_rclk, e_rsdi, e_cclk, e_csdi, e_le, e_oeb, oeb_nd;
        logic [2:0]  e_addr;
        logic [10:0] e_vec, got;
        total  = (w + 1) + 2 * COLS + 2 + 1 + DWELL;
        oeb_nd = BLANK ? 1'b1 : !lit_exp;
        e_addr = 3'(r);
        for (int c = 0; c < total; c++) begin
            {e_req, e_fs, e_rclk, e_rsdi, e_cclk, e_csdi, e_le} = '0;
            e_oeb = oeb_nd;
            if (c <= w) begin
                e_req = 1'b1;
                e_fs  = (c == 0) && (r == 0);
            end else begin
                k = c - (w + 1);
                if (k < 2 * COLS) begin
                    e_csdi = d[COLS - 1 - k / 2];
                    e_cclk = (k % 2) == 1;
                end else if (k < 2 * COLS + 2) begin
                    e_rsdi = (r == 0);
                    e_rclk = (k - 2 * COLS) == 1;
                end else if (k == 2 * COLS + 2) begin
                    e_le = 1'b1;
                end else begin
                    e_oeb = 1'b0;
                end
            end
            e_vec = {e_req, e_addr, e_fs, e_rclk, e_rsdi, e_cclk, e_csdi, e_le, e_oeb};
            got   = obs();
            tests++;
            if (got !== e_vec) begin
                fails++;
                $display("FAIL row_cycle r=%0d c=%0d: got %b required %b (req,addr,fs,rclk,rsdi,cclk,csdi,le,oeb)",
                         r, c, got, e_vec);
            end
            if (frame_start === 1'b1) fs_t.push_back(cyc);
            if (le === 1'b1)          le_t.push_back(cyc);
            if (cclk === 1'b1)        cb.push_back(csdi);

            if (c == abort_at) begin
                reset  = 1'b1;
                fb_ack = 1'b0;
                @(posedge clk); #1;
                tests++;
                if (obs() !== IDLE_VEC) begin
                    fails++;
                    $display("FAIL reset_mid: got %b required %b", obs(), IDLE_VEC);
                end
                reset   = 1'b0;
                lit_exp = 1'b0;
                return;
            end

            // Data is valid only on the ack cycle; other cycles carry junk,
            // and acks outside FETCH are random and must be ignored.
            fb_ack  = (c == w) ? 1'b1 : ((c > w) ? 1'($urandom) : 1'b0);
            fb_data = (c == w) ? d : COLS'($urandom);
            if (dis_at >= 0 && c >= dis_at) enable = 1'b0;
            else if (c == total - 1)        enable = en_end;
            else                            enable = 1'b1;
            @(posedge clk); #1;
        end
        lit_exp = (dis_at >= 0) ? 1'b0 : en_end;
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tests++;
            if (obs() !== IDLE_VEC) begin
                fails++;
                $display("FAIL idle i=%0d: got %b required %b", i, obs(), IDLE_VEC);
            end
            enable  = 1'b0;
            fb_ack  = 1'($urandom);
            fb_data = COLS'($urandom);
            @(posedge clk); #1;
        end
        lit_exp = 1'b0;
    endtask

    task automatic start_scan();
        enable = 1'b1;
        fb_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        fb_ack  = 1'b0;
        fb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs() !== IDLE_VEC) begin
            fails++;
            $display("FAIL reset_state: got %b required %b", obs(), IDLE_VEC);
        end
        reset = 1'b0;
        check_idle(50);
    endtask

    task automatic test_scan_zero_wait();
        logic [COLS-1:0] a5;
        int per;
        a5 = 8'hA5;
        fs_t.delete(); le_t.delete(); cb.delete();
        start_scan();
        for (int i = 0; i < ROWS + 1; i++) begin
            do_row(i % ROWS, (i < ROWS) ? a5 : COLS'($urandom), 0, i != ROWS, -1, -1);
        end
        check_idle(5);
        for (int i = 0; i < COLS; i++) begin
            tests++;
            if (cb.size() < COLS || cb[i] !== a5[COLS - 1 - i]) begin
                fails++;
                $display("FAIL csdi_seq bit%0d: got %0d required %0d", i,
                         (cb.size() > i) ? int'(cb[i]) : -1, a5[COLS - 1 - i]);
            end
        end
        per = (fs_t.size() >= 2) ? fs_t[1] - fs_t[0] : -1;
        tests++;
        if (per !== 288) begin
            fails++;
            $display("FAIL frame_period: got %0d required 288", per);
        end
        tests++;
        if (le_t.size() !== ROWS + 1) begin
            fails++;
            $display("FAIL le_count: got %0d required %0d", le_t.size(), ROWS + 1);
        end
        for (int i = 1; i < le_t.size(); i++) begin
            tests++;
            if (le_t[i] - le_t[i-1] !== 36) begin
                fails++;
                $display("FAIL le_period %0d: got %0d required 36", i, le_t[i] - le_t[i-1]);
            end
        end
    endtask

    task automatic test_ack_delay();
        le_t.delete();
        start_scan();
        for (int i = 0; i < 4; i++) do_row(i, COLS'($urandom), 5, 1'b1, -1, -1);
        for (int i = 4; i < 11; i++)
            do_row(i % ROWS, COLS'($urandom), $urandom_range(0, 7), i != 10, -1, -1);
        check_idle(4);
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (le_t.size() < 4 || le_t[i] - le_t[i-1] !== 41) begin
                fails++;
                $display("FAIL delayed_period %0d: got %0d required 41", i,
                         (le_t.size() >= 4) ? le_t[i] - le_t[i-1] : -1);
            end
        end
    endtask

    task automatic test_disable_mid();
        int w;
        start_scan();
        for (int i = 0; i < 3; i++) do_row(i, COLS'($urandom), $urandom_range(0, 3), 1'b1, -1, -1);
        w = $urandom_range(0, 3);
        do_row(3, COLS'($urandom), w, 1'b0, w + 1 + $urandom_range(0, 2 * COLS - 1), -1);
        check_idle(10);
        start_scan();
        do_row(0, COLS'($urandom), 0, 1'b0, -1, -1);
        check_idle(3);
    endtask

    task automatic test_reset_mid();
        int w;
        start_scan();
        for (int i = 0; i < 5; i++) do_row(i, COLS'($urandom), $urandom_range(0, 2), 1'b1, -1, -1);
        w = $urandom_range(0, 2);
        do_row(5, COLS'($urandom), w, 1'b1, -1, w + 1 + 2 * COLS + 3 + $urandom_range(0, DWELL - 1));
        enable = 1'b1;
        @(posedge clk); #1;
        do_row(0, COLS'($urandom), 0, 1'b1, -1, -1);
        do_row(1, COLS'($urandom), 1, 1'b0, -1, -1);
        check_idle(3);
    endtask

    initial begin
        test_reset();
        test_scan_zero_wait();
        test_ack_delay();
        test_disable_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
